// File: rtl/sgd_add_tree_acc.sv
// sgd_add_tree_acc
//   Masked adder tree over LANES = 2**TREE_DEPTH signed lanes, followed by a
//   saturating accumulate/output register. Each tree stage is registered and
//   grows by one bit, so the tree itself can never overflow. A single global
//   stall (advance) freezes every stage while a result waits downstream.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous reset, ACTIVE HIGH (legacy name kept)
//   acc_mode        0: one result per beat, 1: accumulate until last beat
//   v_input         lane operands (signed, DATA_WIDTH each)
//   v_input_enable  per-lane mask, a disabled lane contributes 0
//   v_input_valid   beat present
//   v_input_last    closes an accumulation group (mode 1 only)
//   v_input_ready   beat accepted when valid && ready
//   v_output        signed ACC_WIDTH result
//   v_output_valid  result present
//   v_output_ovf    result was saturated (qualified by v_output_valid)
//   v_output_ready  downstream accepts result
module sgd_add_tree_acc #(
    parameter int unsigned TREE_DEPTH = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         acc_mode,
    input  logic signed [DATA_WIDTH-1:0] v_input        [2**TREE_DEPTH],
    input  logic                         v_input_enable [2**TREE_DEPTH],
    input  logic                         v_input_valid,
    input  logic                         v_input_last,
    output logic                         v_input_ready,
    output logic signed [ACC_WIDTH-1:0]  v_output,
    output logic                         v_output_valid,
    output logic                         v_output_ovf,
    input  logic                         v_output_ready
);

    localparam int unsigned LANES = 2**TREE_DEPTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic advance;

    always_comb begin
        advance       = !v_output_valid || v_output_ready;
        v_input_ready = advance;
    end

    // Stage 0 is the masked input (combinational); stages 1..TREE_DEPTH are
    // registers holding LANES>>k partial sums of width DATA_WIDTH+k.
    genvar k;
    for (k = 0; k <= TREE_DEPTH; k++) begin : g_stage
        localparam int unsigned N = LANES >> k;
        localparam int unsigned W = DATA_WIDTH + k;

        logic signed [W-1:0] sum [N];
        logic                valid;
        logic                last;
        logic                mode;

        if (k == 0) begin : g_in
            always_comb begin
                for (int unsigned i = 0; i < N; i++) begin
                    sum[i] = v_input_enable[i] ? v_input[i] : '0;
                end
                valid = v_input_valid;
                last  = v_input_last;
                mode  = acc_mode;
            end
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    valid <= 1'b0;
                end else if (advance) begin
                    valid <= g_stage[k-1].valid;
                    last  <= g_stage[k-1].last;
                    mode  <= g_stage[k-1].mode;
                    for (int unsigned i = 0; i < N; i++) begin
                        sum[i] <= W'(g_stage[k-1].sum[2*i]) + W'(g_stage[k-1].sum[2*i+1]);
                    end
                end
            end
        end
    end

    logic                        tree_valid;
    logic                        tree_last;
    logic                        tree_mode;
    logic signed [ACC_WIDTH-1:0] tree_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH:0]   wide;
    logic signed [ACC_WIDTH-1:0] sat_sum;
    logic                        sat_hit;
    logic                        group_open;
    logic                        sticky;

    // One guard bit detects overflow of the accumulate add; clamp to the
    // representable range in the direction of the true sum.
    always_comb begin
        tree_valid = g_stage[TREE_DEPTH].valid;
        tree_last  = g_stage[TREE_DEPTH].last;
        tree_mode  = g_stage[TREE_DEPTH].mode;
        tree_ext   = ACC_WIDTH'(g_stage[TREE_DEPTH].sum[0]);
        base       = group_open ? acc : '0;
        wide       = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(tree_ext);
        sat_hit    = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
        if (!sat_hit) begin
            sat_sum = wide[ACC_WIDTH-1:0];
        end else if (wide[ACC_WIDTH]) begin
            sat_sum = ACC_MIN;
        end else begin
            sat_sum = ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc            <= '0;
            group_open     <= 1'b0;
            sticky         <= 1'b0;
            v_output       <= '0;
            v_output_valid <= 1'b0;
            v_output_ovf   <= 1'b0;
        end else if (advance) begin
            v_output_valid <= 1'b0;
            if (tree_valid) begin
                if (!tree_mode) begin
                    // pass-through beat; an open group is left untouched
                    v_output       <= tree_ext;
                    v_output_ovf   <= 1'b0;
                    v_output_valid <= 1'b1;
                end else if (tree_last) begin
                    v_output       <= sat_sum;
                    v_output_ovf   <= sticky || sat_hit;
                    v_output_valid <= 1'b1;
                    acc            <= '0;
                    group_open     <= 1'b0;
                    sticky         <= 1'b0;
                end else begin
                    acc        <= sat_sum;
                    group_open <= 1'b1;
                    sticky     <= sticky || sat_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_sgd_add_tree_acc.sv
module tb_sgd_add_tree_acc;

    localparam int unsigned TD = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 48;
    localparam int unsigned NL = 8;

    localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW-1));

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 acc_mode;
    logic signed [DW-1:0] v_input        [NL];
    logic                 v_input_enable [NL];
    logic                 v_input_valid;
    logic                 v_input_last;
    logic                 v_input_ready;
    logic signed [AW-1:0] v_output;
    logic                 v_output_valid;
    logic                 v_output_ovf;
    logic                 v_output_ready;

    sgd_add_tree_acc #(
        .TREE_DEPTH(TD),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .acc_mode      (acc_mode),
        .v_input       (v_input),
        .v_input_enable(v_input_enable),
        .v_input_valid (v_input_valid),
        .v_input_last  (v_input_last),
        .v_input_ready (v_input_ready),
        .v_output      (v_output),
        .v_output_valid(v_output_valid),
        .v_output_ovf  (v_output_ovf),
        .v_output_ready(v_output_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int stall_cnt = 0;

    longint exp_v[$];
    bit     exp_o[$];
    longint log_v[$];
    bit     log_o[$];
    int     log_c[$];

    longint m_acc = 0;
    bit     m_open = 0;
    bit     m_sticky = 0;
    bit     prev_stall = 0;
    longint prev_v = 0;
    bit     prev_o = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: beats are folded into expected results at acceptance,
    // outputs are checked in order whenever a result is handed downstream.
    always @(negedge clk) begin
        longint s;
        longint r;
        bit     o;
        cyc++;
        if (rst_n) begin
            m_acc = 0; m_open = 0; m_sticky = 0;
            exp_v.delete(); exp_o.delete();
            prev_stall = 0;
        end else begin
            chk("in_ready", longint'(v_input_ready), longint'(!v_output_valid || v_output_ready));
            if (!v_input_ready) stall_cnt++;
            if (prev_stall) begin
                chk("hold_valid", longint'(v_output_valid), 1);
                chk("hold_value", v_output, prev_v);
                chk("hold_ovf", longint'(v_output_ovf), longint'(prev_o));
            end
            if (v_output_valid && v_output_ready) begin
                if (exp_v.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0d expected no output", v_output);
                end else begin
                    chk("out_value", v_output, exp_v.pop_front());
                    chk("out_ovf", longint'(v_output_ovf), longint'(exp_o.pop_front()));
                end
                log_v.push_back(v_output);
                log_o.push_back(v_output_ovf);
                log_c.push_back(cyc);
            end
            if (v_input_valid && v_input_ready) begin
                acc_cyc = cyc;
                s = 0;
                for (int i = 0; i < NL; i++) if (v_input_enable[i]) s += v_input[i];
                if (!acc_mode) begin
                    exp_v.push_back(s); exp_o.push_back(1'b0);
                end else begin
                    r = (m_open ? m_acc : 0) + s;
                    o = 0;
                    if (r > AMAX) begin r = AMAX; o = 1; end
                    if (r < AMIN) begin r = AMIN; o = 1; end
                    if (v_input_last) begin
                        exp_v.push_back(r); exp_o.push_back(m_sticky | o);
                        m_acc = 0; m_open = 0; m_sticky = 0;
                    end else begin
                        m_acc = r; m_open = 1; m_sticky = m_sticky | o;
                    end
                end
            end
            prev_stall = v_output_valid && !v_output_ready;
            prev_v = v_output;
            prev_o = v_output_ovf;
        end
    end

    task automatic drive(input bit m, input bit l, input bit [7:0] en, input int base, input int step);
        int w;
        for (int i = 0; i < NL; i++) begin
            v_input[i] = base + step * i;
            v_input_enable[i] = en[i];
        end
        acc_mode = m;
        v_input_last = l;
        v_input_valid = 1'b1;
        @(negedge clk);
        w = 0;
        while (!v_input_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", w);
        end
        @(posedge clk); #1;
        v_input_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        v_input_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_v.delete(); log_o.delete(); log_c.delete();
    endtask

    initial begin
        rst_n = 1'b1;
        acc_mode = 1'b0;
        v_input_valid = 1'b0;
        v_input_last = 1'b0;
        v_output_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            v_input[i] = '0;
            v_input_enable[i] = 1'b0;
        end

        // reset state, sampled while reset is still held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", longint'(v_output_valid), 0);
        chk("rst_value", v_output, 0);
        chk("rst_ovf", longint'(v_output_ovf), 0);
        chk("rst_ready", longint'(v_input_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle(2);

        // mode 0, lanes 0..7, odd lanes enabled -> 1+3+5+7
        clear_log();
        drive(0, 0, 8'hAA, 0, 1);
        idle(10);
        chk("t1_count", log_v.size(), 1);
        if (log_v.size() >= 1) begin
            chk("t1_value", log_v[0], 16);
            chk("t1_ovf", longint'(log_o[0]), 0);
            chk("t1_latency", log_c[0] - acc_cyc, 4);
        end

        // mode 1, three beats of eight ones
        clear_log();
        drive(1, 0, 8'hFF, 1, 0);
        drive(1, 0, 8'hFF, 1, 0);
        drive(1, 1, 8'hFF, 1, 0);
        idle(10);
        chk("t2_count", log_v.size(), 1);
        if (log_v.size() >= 1) begin
            chk("t2_value", log_v[0], 24);
            chk("t2_ovf", longint'(log_o[0]), 0);
            chk("t2_latency", log_c[0] - acc_cyc, 4);
        end

        // back-to-back mode 0 with a 5-cycle downstream stall
        clear_log();
        stall_cnt = 0;
        fork
            begin
                for (int b = 1; b <= 8; b++) drive(0, 0, 8'h01, 10 * b, 0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 v_output_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 v_output_ready = 1'b1;
            end
        join
        idle(10);
        chk("t3_count", log_v.size(), 8);
        for (int b = 0; b < 8 && b < log_v.size(); b++) chk("t3_order", log_v[b], 10 * (b + 1));
        chk("t3_stall_cycles", stall_cnt, 5);

        // saturation of a long group, then a clean single-beat group
        clear_log();
        for (int b = 0; b < 40000; b++) drive(1, 0, 8'hFF, 32'h7FFFFFFF, 0);
        drive(1, 1, 8'hFF, 32'h7FFFFFFF, 0);
        drive(1, 1, 8'h01, 8, 0);
        idle(10);
        chk("t4_count", log_v.size(), 2);
        if (log_v.size() >= 2) begin
            chk("t4_sat_value", log_v[0], 64'sd140737488355327);
            chk("t4_sat_ovf", longint'(log_o[0]), 1);
            chk("t4_next_value", log_v[1], 8);
            chk("t4_next_ovf", longint'(log_o[1]), 0);
        end

        // reset in the middle of an open group
        clear_log();
        drive(1, 0, 8'h01, 8, 0);
        drive(1, 0, 8'h01, 8, 0);
        idle(2);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle(5);
        chk("t5_no_output", log_v.size(), 0);
        drive(1, 1, 8'h01, 8, 0);
        idle(10);
        chk("t5_count", log_v.size(), 1);
        if (log_v.size() >= 1) chk("t5_value", log_v[0], 8);

        // mode 0 beat inside an open mode 1 group
        clear_log();
        drive(1, 0, 8'h01, 8, 0);
        drive(0, 0, 8'h01, 5, 0);
        drive(1, 1, 8'h01, 8, 0);
        idle(10);
        chk("t6_count", log_v.size(), 2);
        if (log_v.size() >= 2) begin
            chk("t6_first", log_v[0], 5);
            chk("t6_second", log_v[1], 16);
        end

        // bubbles carrying junk last/mode, then an all-disabled closing beat
        clear_log();
        drive(1, 0, 8'h01, 8, 0);
        acc_mode = 1'b1;
        v_input_last = 1'b1;
        for (int i = 0; i < NL; i++) begin
            v_input[i] = 100;
            v_input_enable[i] = 1'b1;
        end
        idle(3);
        drive(1, 1, 8'h00, 77, 0);
        idle(10);
        chk("t7_count", log_v.size(), 1);
        if (log_v.size() >= 1) chk("t7_value", log_v[0], 8);

        // most negative lanes, sign extension through the tree
        clear_log();
        drive(0, 0, 8'hFF, int'(32'h80000000), 0);
        idle(10);
        chk("t8_count", log_v.size(), 1);
        if (log_v.size() >= 1) chk("t8_value", log_v[0], -64'sd17179869184);

        chk("pending_results", exp_v.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sgd_add_tree_acc.md
SGD_ADD_TREE_ACC -- requirements
Module: sgd_add_tree_acc

Interface
REQ-001 SHALL have parameter TREE_DEPTH, default 3, log2 of lane count; LANES = 2**TREE_DEPTH, TREE_DEPTH range 1..6.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed width of each lane input.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, signed accumulator/output width, ACC_WIDTH >= DATA_WIDTH+TREE_DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-high reset (asserted = 1); port name kept for codebase compatibility.
REQ-006 SHALL have port acc_mode  input  1  0 = per-beat sum, 1 = accumulate beats until last; sampled with each accepted beat.
REQ-007 SHALL have port v_input  input  LANES x DATA_WIDTH signed (unpacked array)  lane operands.
REQ-008 SHALL have port v_input_enable  input  LANES x 1 (unpacked array)  per-lane mask; disabled lane contributes 0.
REQ-009 SHALL have port v_input_valid  input  1  beat present.
REQ-010 SHALL have port v_input_last  input  1  closes an accumulation group (ignored when acc_mode=0).
REQ-011 SHALL have port v_input_ready  output  1  beat accepted when valid && ready.
REQ-012 SHALL have port v_output  output  ACC_WIDTH signed  result.
REQ-013 SHALL have port v_output_valid  output  1  result present.
REQ-014 SHALL have port v_output_ovf  output  1  result saturated; qualified by v_output_valid.
REQ-015 SHALL have port v_output_ready  input  1  downstream accepts result.

Function
REQ-016 SHALL compute masked sum of enabled lanes in a binary tree of TREE_DEPTH registered stages; stage k width DATA_WIDTH+k, sign-extended, never overflows.
REQ-017 SHALL carry valid, last and mode bits alongside data through every tree stage.
REQ-018 SHALL follow tree with one accumulate/output register stage; latency accepted beat -> v_output_valid = TREE_DEPTH+1 cycles when unstalled.
REQ-019 SHALL use global stall: advance = !v_output_valid || v_output_ready; all stages hold when advance=0; v_input_ready = advance.
REQ-020 SHALL, mode 0: emit tree sum sign-extended to ACC_WIDTH, v_output_ovf=0.
REQ-021 SHALL, mode 1, non-last beat: acc <= (group_open ? acc : 0) + sum, group_open <= 1, no output.
REQ-022 SHALL, mode 1, last beat: emit (group_open ? acc : 0) + sum, then acc <= 0, group_open <= 0; single-beat group (last on first beat) emits that beat's sum.
REQ-023 SHALL saturate every accumulate add to [-2**(ACC_WIDTH-1), 2**(ACC_WIDTH-1)-1]; sticky ovf set on any saturation in group, reported with group result, cleared after emission.
REQ-024 SHALL pass a mode-0 beat arriving inside an open mode-1 group as independent output, leaving acc/group_open unchanged.
REQ-025 SHALL hold v_output, v_output_ovf stable while v_output_valid && !v_output_ready.
REQ-026 SHALL treat all-lanes-disabled valid beat as sum 0 (still counts as beat, honours last).
REQ-027 SHALL ignore v_input, enable, last, mode when v_input_valid=0 (bubble propagates, no acc change).

Reset
REQ-028 SHALL, while rst_n=1 at clk edge: clear all stage valid bits, acc=0, group_open=0, sticky ovf=0, v_output=0, v_output_valid=0, v_output_ovf=0.
REQ-029 SHALL drive v_input_ready=1 during and after reset (pipeline empty).
REQ-030 SHALL discard in-flight beats and partial group on reset mid-operation; first post-reset group starts from 0.

Verification (TREE_DEPTH=3, DATA_WIDTH=32, ACC_WIDTH=48)
REQ-031 Mode 0, lanes 0..7 = 0..7, enable odd lanes, one beat, ready=1 -> v_output=16 exactly 4 cycles later, ovf=0, one valid cycle.
REQ-032 Mode 1, 3 beats all lanes=1 all enabled, last on beat 3 -> single output 24 after beat 3 + 4 cycles; no output for beats 1-2.
REQ-033 Back-to-back mode-0 beats, v_output_ready low 5 cycles -> v_input_ready low same cycles, output held, no beat lost or duplicated, order preserved.
REQ-034 Mode 1, lanes=0x7FFFFFFF all enabled, 40000 beats then last -> v_output=2**47-1, v_output_ovf=1; next group of one beat value 8 -> 8, ovf=0.
REQ-035 Mode 1 group open (2 beats of 8), rst_n pulsed 1 cycle -> no output; next single-beat last group of 8 -> 8.
REQ-036 Mode-0 beat (sum 5) between mode-1 beats (sum 8, then sum 8 with last) -> outputs 5 then 16.
